// File: rtl/fp8_pkg.sv
// fp8_pkg: shared E4M3/BF16 constants, lane types and the per-lane BF16 decoder
package fp8_pkg;
  localparam int E4M3_BIAS = 7;
  localparam int E4M3_EXP_W = 4;
  localparam int E4M3_MAN_W = 3;
  localparam logic [6:0] E4M3_MAX_POS = 7'h7E;
  localparam logic [6:0] E4M3_NAN = 7'h7F;
  localparam int BF16_BIAS = 127;
  typedef enum logic {RND_RNE = 1'b0, RND_RTZ = 1'b1} rnd_mode_e;
  typedef enum logic [2:0] {CLS_ZERO, CLS_DENORM, CLS_NORM, CLS_INF, CLS_NAN} cls_e;
  typedef struct packed {
    logic sign;
    cls_e cls;
    logic [8:0] te;
    logic [E4M3_MAN_W-1:0] mant;
    logic g;
    logic r;
    logic s;
    rnd_mode_e rnd;
  } s1_lane_t;
  function automatic s1_lane_t bf16_decode(input logic [15:0] x, input logic rm);
    s1_lane_t l;
    logic [15:0] sh;
    logic [2:0] amt;
    logic live;
    l.sign = x[15];
    l.cls = x[14:7] == 8'hFF ? (|x[6:0] ? CLS_NAN : CLS_INF) :
            x[14:7] == 8'h00 ? (|x[6:0] ? CLS_DENORM : CLS_ZERO) : CLS_NORM;
    l.te = {1'b0, x[14:7]} - 9'(BF16_BIAS - E4M3_BIAS);
    amt = $signed(l.te) > 0 ? 3'd0 : 3'(9'd1 - l.te);
    sh = {1'b1, x[6:0], 8'h00} >> amt;
    live = l.cls == CLS_NORM && $signed(l.te) >= -3;
    l.mant = live ? sh[14:12] : '0;
    l.g = live & sh[11];
    l.r = live & sh[10];
    l.s = l.cls == CLS_NORM && (!live || |sh[9:0]);
    l.rnd = rnd_mode_e'(rm);
    return l;
  endfunction
endpackage

// File: rtl/bf16_to_fp8_lane_round.sv
// bf16_to_fp8_lane_round: rounds one decoded lane and encodes the final E4M3 byte and event flags
module bf16_to_fp8_lane_round import fp8_pkg::*; #(
  parameter bit SATURATE = 1'b1
) (
  input  s1_lane_t    i_lane,
  output logic [7:0]  o_fp8,
  output logic        o_ovf,
  output logic        o_unf,
  output logic        o_nan,
  output logic        o_inx
);
  logic [E4M3_EXP_W-1:0] w_exp;
  logic w_inc;
  logic w_norm;
  logic w_big;
  logic [7:0] w_rnd;
  // Round the kept bits (a carry flows into the exponent), then pick special or finite encoding.
  always_comb begin
    w_norm = i_lane.cls == CLS_NORM;
    w_exp = $signed(i_lane.te) > 0 ? i_lane.te[E4M3_EXP_W-1:0] : '0;
    w_inc = i_lane.rnd == RND_RNE && i_lane.g && (i_lane.r || i_lane.s || i_lane.mant[0]);
    w_rnd = {1'b0, w_exp, i_lane.mant} + {7'd0, w_inc};
    w_big = i_lane.cls == CLS_INF ||
            (w_norm && ($signed(i_lane.te) > 15 || w_rnd >= {1'b0, E4M3_NAN}));
    o_nan = i_lane.cls == CLS_NAN;
    o_ovf = w_big;
    o_unf = i_lane.cls == CLS_DENORM || (w_norm && !w_big && w_rnd == 8'd0);
    o_inx = i_lane.cls == CLS_DENORM || w_big || (w_norm && (i_lane.g || i_lane.r || i_lane.s));
    o_fp8 = o_nan ? {i_lane.sign, E4M3_NAN} :
            w_big ? {i_lane.sign, SATURATE ? E4M3_MAX_POS : E4M3_NAN} :
            {i_lane.sign, w_norm ? w_rnd[6:0] : 7'h00};
  end
endmodule

// File: rtl/bf16_to_fp8_pipe.sv
// bf16_to_fp8_pipe: multi-lane two-stage BF16 to FP8 E4M3 converter with handshake and sticky flags
module bf16_to_fp8_pipe import fp8_pkg::*; #(
  parameter int LANES    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [16*LANES-1:0] in_data,
  input  logic               rnd_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  input  logic               flags_clr,
  output logic               flag_ovf,
  output logic               flag_unf,
  output logic               flag_nan,
  output logic               flag_inx
);
  logic w_adv;
  logic r_s1_valid;
  s1_lane_t [LANES-1:0] r_s1;
  s1_lane_t [LANES-1:0] w_dec;
  logic [8*LANES-1:0] w_out;
  logic [LANES-1:0] w_ovf;
  logic [LANES-1:0] w_unf;
  logic [LANES-1:0] w_nan;
  logic [LANES-1:0] w_inx;
  logic [3:0] r_s2_flags;
  assign w_adv = !out_valid || out_ready;
  assign in_ready = w_adv;
  // Decode every lane of the incoming beat into sign/class/exponent/aligned significand.
  always_comb begin
    for (int i = 0; i < LANES; i++) w_dec[i] = bf16_decode(in_data[16*i +: 16], rnd_mode);
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bf16_to_fp8_lane_round #(.SATURATE(SATURATE)) u_round (
      .i_lane (r_s1[g]),
      .o_fp8  (w_out[8*g +: 8]),
      .o_ovf  (w_ovf[g]),
      .o_unf  (w_unf[g]),
      .o_nan  (w_nan[g]),
      .o_inx  (w_inx[g])
    );
  end
  // Both stages move together whenever S2 is empty or being drained; otherwise everything holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1 <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      r_s2_flags <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1 <= w_dec;
      out_valid <= r_s1_valid;
      out_data <= w_out;
      r_s2_flags <= {|w_ovf, |w_unf, |w_nan, |w_inx};
    end
  end
  // Sticky flags collect the events of each beat as it leaves S2; a clear never masks new events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {flag_ovf, flag_unf, flag_nan, flag_inx} <= '0;
    else {flag_ovf, flag_unf, flag_nan, flag_inx} <=
      (flags_clr ? 4'd0 : {flag_ovf, flag_unf, flag_nan, flag_inx}) |
      (out_valid && out_ready ? r_s2_flags : 4'd0);
  end
endmodule
